// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame controller: FSM state encoding,
// error codes reported with frame_err, and the default sync value.
package uart_frame_pkg;

  // FSM state encoding
  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] LEN_LO  = 3'd1;
  localparam logic [2:0] LEN_HI  = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] CHECK   = 3'd4;

  // Error codes; err_code holds the last one reported
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CKSUM = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Idle clock cycles that count as a line gap: GAP_BYTES byte-times of
  // 10 bit-times each (start + 8 data + stop).
  function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                 input int unsigned baud_rate,
                                                 input int unsigned gap_bytes);
    return gap_bytes * 10 * (clk_freq / baud_rate);
  endfunction

endpackage

// File: rtl/uart_frame_controller_byte_fifo.sv
// Synchronous byte FIFO. A push is accepted when not full, or when full
// with a same-cycle pop. Read data comes straight from storage, so it is
// stable for as long as the head entry is not popped; it reads 0 when empty.
module byte_fifo
  import uart_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  // Storage write
  // NOTE: the data array has no reset; only pointers and occupancy define
  // what is valid, so resetting storage would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; pointers wrap modulo DEPTH
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_frame_controller.sv
// UART frame controller: assembles LSB-first bytes from receiver bit
// pulses, hunts for the sync byte, parses a 16-bit little-endian length,
// forwards payload through a small FIFO and checks an XOR checksum.
// A line gap of GAP_BYTES byte-times resynchronises the bit counter and
// aborts any frame in progress.
module uart_frame_controller
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int unsigned GAP_BYTES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bit,
  input  logic       rx_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned TIMEOUT = timeout_cycles(CLK_FREQ, BAUD_RATE, GAP_BYTES);
  localparam int unsigned GAP_W   = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             gap_timeout;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt;
  logic             byte_valid;
  logic [2:0]       state;
  logic [7:0]       len_lo;
  logic [15:0]      remaining;
  logic [7:0]       checksum;
  logic             ovf;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  // Gap timer: cleared by each bit pulse, otherwise counts up and saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (rx_valid) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_MAX) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Single-cycle strobe on the cycle the timer reaches TIMEOUT
  assign gap_timeout = !rx_valid && (gap_cnt == GAP_LAST);

  // Byte assembler: LSB-first shift; the 8th bit raises byte_valid for one
  // cycle, during which shift_reg holds the complete byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (rx_valid) begin
        shift_reg <= {rx_bit, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_valid <= 1'b1;
      end else if (gap_timeout) begin
        bit_cnt <= '0;
      end
    end
  end

  // Frame FSM; a timeout abort takes priority over byte processing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HUNT;
      len_lo      <= '0;
      remaining   <= '0;
      checksum    <= '0;
      ovf         <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      if (gap_timeout && (state != HUNT)) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
        state     <= HUNT;
        ovf       <= 1'b0;
      end else if (byte_valid) begin
        case (state)
          HUNT: begin
            if (shift_reg == SYNC_BYTE) begin
              state       <= LEN_LO;
              frame_start <= 1'b1;
            end
          end
          LEN_LO: begin
            len_lo <= shift_reg;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            // Checksum is cleared for zero-length frames too, so their
            // check byte is always compared against 00.
            remaining <= {shift_reg, len_lo};
            checksum  <= '0;
            state     <= ({shift_reg, len_lo} == 16'd0) ? CHECK : PAYLOAD;
          end
          PAYLOAD: begin
            checksum  <= checksum ^ shift_reg;
            remaining <= remaining - 16'd1;
            if (fifo_full && !fifo_pop) ovf <= 1'b1;
            if (remaining == 16'd1) state <= CHECK;
          end
          CHECK: begin
            if (ovf) begin
              frame_err <= 1'b1;
              err_code  <= ERR_OVF;
            end else if (shift_reg != checksum) begin
              frame_err <= 1'b1;
              err_code  <= ERR_CKSUM;
            end else begin
              frame_done <= 1'b1;
            end
            state <= HUNT;
            ovf   <= 1'b0;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Payload bytes are pushed in the byte_valid cycle; a full FIFO without a
  // same-cycle pop drops the byte inside the FIFO (flagged above as ovf).
  assign fifo_push = byte_valid && (state == PAYLOAD) && !gap_timeout;
  assign fifo_pop  = m_valid && m_ready;
  assign m_valid   = !fifo_empty;
  assign busy      = (state != HUNT);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (shift_reg),
    .pop       (fifo_pop),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_frame_controller.sv
// Bench for uart_frame_controller. Frames are described at byte level;
// the expected payload stream and frame events are derived from the frame
// contents (XOR of payload, FIFO capacity) and checked by a monitor.
module tb_uart_frame_controller;

  localparam int unsigned CLK_FREQ   = 1_000_000;
  localparam int unsigned BAUD_RATE  = 100_000;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned GAP_BYTES  = 4;
  localparam int unsigned TIMEOUT    = GAP_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam logic [7:0]  SYNC       = 8'hA5;

  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_DONE  = 2'd1;
  localparam logic [1:0] EV_ERR   = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] code;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_bit = 1'b0;
  logic       rx_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  evt_t       exp_evt[$];
  logic [7:0] exp_data[$];
  logic [7:0] pl[$];
  logic [7:0] gb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         drained = 0;
  bit         rand_ready = 1'b0;

  uart_frame_controller #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_BYTE  (SYNC),
    .GAP_BYTES  (GAP_BYTES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_bit      (rx_bit),
    .rx_valid    (rx_valid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: checks frame events in order, the payload stream against
  // exp_data, pulse exclusivity and m_data stability while stalled.
  int         npulse;
  logic [1:0] kind;
  evt_t       ev;
  bit         hold_pending = 1'b0;
  logic [7:0] hold_data;

  always @(negedge clk) begin
    if (rst) begin
      npulse = int'(frame_start) + int'(frame_done) + int'(frame_err);
      if (npulse > 1) begin
        check("pulse_excl", npulse, 1);
      end else if (npulse == 1) begin
        kind = frame_start ? EV_START : (frame_done ? EV_DONE : EV_ERR);
        if (exp_evt.size() == 0) begin
          check("unexpected_evt", {30'd0, kind} + 32'd1, 32'd0);
        end else begin
          ev = exp_evt.pop_front();
          check("evt_kind", kind, ev.kind);
          if (kind == EV_ERR) check("err_code", err_code, ev.code);
        end
      end
      if (hold_pending && m_valid) check("m_data_hold", m_data, hold_data);
      hold_pending = m_valid && !m_ready;
      hold_data    = m_data;
      if (m_valid && m_ready) begin
        drained++;
        if (exp_data.size() == 0) check("unexpected_data", m_data + 32'h100, 32'h0);
        else check("m_data", m_data, exp_data.pop_front());
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic b, input int idle);
    rx_valid = 1'b1;
    rx_bit   = b;
    step();
    rx_valid = 1'b0;
    rx_bit   = 1'($urandom);
    repeat (idle) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit no_tail);
    for (int i = 0; i < 8; i++)
      send_bit(b[i], (i == 7 && no_tail) ? 0 : int'($urandom_range(0, 2)));
  endtask

  // Sends garbage gb, then SYNC, len=pl.size(), payload pl and the
  // checksum byte XORed with cks_xor. Expectations are queued before the
  // byte that triggers them.
  task automatic send_frame(input logic [7:0] cks_xor, input bit lat_check);
    logic [7:0]  cks;
    logic [15:0] len;
    int          free;
    bit          ovf;
    cks = 8'h00;
    len = 16'(pl.size());
    foreach (gb[i]) send_byte(gb[i], 1'b0);
    exp_evt.push_back('{kind: EV_START, code: 2'b00});
    send_byte(SYNC, 1'b0);
    send_byte(len[7:0], 1'b0);
    send_byte(len[15:8], 1'b0);
    free = (rand_ready || m_ready) ? pl.size() : int'(FIFO_DEPTH) - exp_data.size();
    ovf  = pl.size() > free;
    foreach (pl[i]) begin
      cks ^= pl[i];
      if (i < free) exp_data.push_back(pl[i]);
      if (lat_check) begin
        send_byte(pl[i], 1'b1);
        @(negedge clk);
        check("lat_t1_valid", m_valid, 1'b0);
        @(negedge clk);
        check("lat_t2_valid", m_valid, 1'b1);
        check("lat_t2_data", m_data, pl[i]);
        step();
      end else begin
        send_byte(pl[i], 1'b0);
      end
    end
    if (ovf)                exp_evt.push_back('{kind: EV_ERR, code: 2'b10});
    else if (cks_xor != 0)  exp_evt.push_back('{kind: EV_ERR, code: 2'b01});
    else                    exp_evt.push_back('{kind: EV_DONE, code: 2'b00});
    send_byte(cks ^ cks_xor, 1'b0);
    repeat (3) step();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_data.size() != 0; i++) step();
    repeat (2) step();
    check({tag, "_left"}, exp_data.size(), 0);
    check({tag, "_mvalid"}, m_valid, 1'b0);
    check({tag, "_evt_left"}, exp_evt.size(), 0);
  endtask

  task automatic rand_payload(input int n);
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst = 1'b0;
    #2;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_start", frame_start, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_err_code", err_code, 2'b00);
    check("rst_busy", busy, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();

    // 1: good frame, latency checked per payload byte
    m_ready = 1'b1;
    gb = {};
    pl = {8'h11, 8'h22, 8'h33};
    send_frame(8'h00, 1'b1);
    wait_drain("t1");
    check("t1_err_code", err_code, 2'b00);

    // 2: bad checksum (01 instead of 00)
    send_frame(8'h01, 1'b0);
    wait_drain("t2");
    check("t2_busy", busy, 1'b0);

    // 3: overflow with stalled sink, then drain exactly FIFO_DEPTH bytes
    m_ready = 1'b0;
    drained = 0;
    rand_payload(20);
    send_frame(8'h00, 1'b0);
    check("t3_evt_left", exp_evt.size(), 0);
    check("t3_held_valid", m_valid, 1'b1);
    check("t3_held_data", m_data, exp_data[0]);
    m_ready = 1'b1;
    wait_drain("t3");
    check("t3_drained", drained, FIFO_DEPTH);

    // 4: garbage, sync, len=0, wrong check byte
    gb = {8'h00, 8'h7F};
    pl = {};
    send_frame(8'h5A, 1'b0);
    wait_drain("t4");
    gb = {};

    // 5: timeout mid-frame (with a partial byte), partial byte in HUNT,
    //    then a good frame
    exp_evt.push_back('{kind: EV_START, code: 2'b00});
    send_byte(SYNC, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_data.push_back(8'h11);
    send_byte(8'h11, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 0);
    exp_evt.push_back('{kind: EV_ERR, code: 2'b11});
    repeat (TIMEOUT + 5) step();
    check("t5_evt_left", exp_evt.size(), 0);
    check("t5_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    repeat (TIMEOUT + 5) step();
    rand_payload(4);
    send_frame(8'h00, 1'b0);
    wait_drain("t5");

    // 6: asynchronous reset mid-payload with 3 bytes in the FIFO
    m_ready = 1'b0;
    exp_evt.push_back('{kind: EV_START, code: 2'b00});
    send_byte(SYNC, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    rand_payload(3);
    foreach (pl[i]) begin
      exp_data.push_back(pl[i]);
      send_byte(pl[i], 1'b0);
    end
    repeat (2) step();
    check("t6_pre_valid", m_valid, 1'b1);
    check("t6_pre_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", m_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_data", m_data, 8'h00);
    exp_data = {};
    exp_evt  = {};
    repeat (3) step();
    rst = 1'b1;
    m_ready = 1'b1;
    step();
    rand_payload(6);
    send_frame(8'h00, 1'b0);
    wait_drain("t6");

    // Random frames with random sink readiness
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      gb = {};
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        gb.push_back(b);
      end
      rand_payload(int'($urandom_range(1, 12)));
      send_frame(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b0);
      for (int i = 0; i < 400 && exp_data.size() != 0; i++) step();
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    wait_drain("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
